// File: rtl/bexkat1_pkg.sv
// bexkat1 shared definitions for the memory/writeback stage.
//   mem_op_t    : operation class handed down from execute
//   mem_state_t : mem_stage control states
//   SZ_*        : register-file byte_en size codes (0 is "no write")
//   SP_STEP     : stack pointer adjustment for PUSH/POP
package bexkat1_pkg;

  typedef enum logic [2:0] {
    MemNone  = 3'd0,
    MemLoad  = 3'd1,
    MemStore = 3'd2,
    MemPush  = 3'd3,
    MemPop   = 3'd4
  } mem_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StWb
  } mem_state_t;

  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd3;

  localparam int unsigned SP_STEP = 4;

  // Size code 0 also means word on the input side; fold it to 3 so it can
  // be used directly as a write enable.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == SZ_BYTE || size == SZ_HALF) ? size : SZ_WORD;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational big-endian lane steering for a 32-bit bus.
//   size        : normalised size code (SZ_BYTE/SZ_HALF/SZ_WORD)
//   addr        : byte offset within the word
//   st_data     : right-justified store data
//   ld_raw      : raw bus read data
//   sel         : byte-lane select, bit 3 = byte 0
//   misalign    : access does not fit its natural alignment
//   st_rep      : store data replicated across all lanes
//   ld_data     : selected lane(s), right-justified, zero-extended
module mem_lane_align
  import bexkat1_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [3:0]  sel,
  output logic        misalign,
  output logic [31:0] st_rep,
  output logic [31:0] ld_data
);

  always_comb begin
    sel      = 4'b1111;
    misalign = 1'b0;
    st_rep   = st_data;
    ld_data  = ld_raw;
    case (size)
      SZ_BYTE: begin
        sel     = 4'b1000 >> addr;
        st_rep  = {4{st_data[7:0]}};
        // byte n lives at bit 8*(3-n); ~addr == 3-addr for 2 bits
        ld_data = {24'b0, ld_raw[{~addr, 3'b000} +: 8]};
      end
      SZ_HALF: begin
        sel      = addr[1] ? 4'b0011 : 4'b1100;
        misalign = addr[0];
        st_rep   = {2{st_data[15:0]}};
        ld_data  = {16'b0, ld_raw[{~addr[1], 4'b0000} +: 16]};
      end
      default: begin
        misalign = |addr;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// bexkat1 memory/writeback stage. Accepts one op per handshake, runs at most
// one classic bus cycle, and retires exactly one register-file write cycle.
// Lane steering assumes WIDTH = 32.
//   in_*     : op from execute (valid/ready handshake)
//   bus_*    : classic bus master (cyc/stb/we/adr/sel/dat, ack/err)
//   rf_*     : register-file general and SP write ports, one-cycle strobes
//   fault*   : one-cycle fault pulse, faulting address held until next fault
// Optional: define MEM_TIMEOUT_EN to abort bus cycles after TIMEOUT cycles
// without a response.
module mem_stage
  import bexkat1_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned COUNTP  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [1:0]        in_size,
  input  logic [WIDTH-1:0]  in_addr,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [COUNTP-1:0] in_dest,
  input  logic              in_wr,
  input  logic [WIDTH-1:0]  in_sp,
  output logic              bus_cyc,
  output logic              bus_stb,
  output logic              bus_we,
  output logic [WIDTH-1:0]  bus_adr,
  output logic [3:0]        bus_sel,
  output logic [WIDTH-1:0]  bus_dat_o,
  input  logic [WIDTH-1:0]  bus_dat_i,
  input  logic              bus_ack,
  input  logic              bus_err,
  output logic [COUNTP-1:0] rf_write_addr,
  output logic [WIDTH-1:0]  rf_write_data,
  output logic [1:0]        rf_write_en,
  output logic [WIDTH-1:0]  rf_sp_data,
  output logic [1:0]        rf_sp_en,
  output logic              fault,
  output logic [WIDTH-1:0]  fault_addr
);

  mem_state_t        state_q, state_d;
  mem_op_t           op_q, op_d;
  logic [1:0]        size_q, size_d;
  logic [COUNTP-1:0] dest_q, dest_d;
  logic              wr_q, wr_d;
  logic [WIDTH-1:0]  sp_new_q, sp_new_d;

  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [WIDTH-1:0]  adr_q, adr_d;
  logic [3:0]        sel_q, sel_d;
  logic [WIDTH-1:0]  dat_q, dat_d;

  logic [COUNTP-1:0] waddr_q, waddr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [1:0]        wen_q, wen_d;
  logic [WIDTH-1:0]  sp_data_q, sp_data_d;
  logic [1:0]        sp_en_q, sp_en_d;
  logic              fault_q, fault_d;
  logic [WIDTH-1:0]  fault_addr_q, fault_addr_d;

  // Accept-side decode
  mem_op_t          in_op_e;
  logic             is_mem;
  logic [WIDTH-1:0] acc_adr;
  logic [1:0]       acc_size;

  assign in_op_e = mem_op_t'(in_op);

  always_comb begin
    acc_adr  = in_addr;
    acc_size = norm_size(in_size);
    is_mem   = 1'b1;
    case (in_op_e)
      MemLoad, MemStore: is_mem = 1'b1;
      MemPush: begin
        acc_adr  = in_sp - WIDTH'(SP_STEP);
        acc_size = SZ_WORD;
      end
      MemPop: begin
        acc_adr  = in_sp;
        acc_size = SZ_WORD;
      end
      default: is_mem = 1'b0;
    endcase
  end

  // One aligner: fed from the incoming op while idle, from the captured op
  // while the bus cycle is in flight (only the load path matters then).
  logic [1:0]       al_size;
  logic [1:0]       al_addr;
  logic [3:0]       al_sel;
  logic             al_misalign;
  logic [WIDTH-1:0] al_st;
  logic [WIDTH-1:0] al_ld;

  assign al_size = (state_q == StIdle) ? acc_size     : size_q;
  assign al_addr = (state_q == StIdle) ? acc_adr[1:0] : adr_q[1:0];

  mem_lane_align u_align (
    .size     (al_size),
    .addr     (al_addr),
    .st_data  (in_data),
    .ld_raw   (bus_dat_i),
    .sel      (al_sel),
    .misalign (al_misalign),
    .st_rep   (al_st),
    .ld_data  (al_ld)
  );

  logic timeout_hit;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q;

  assign timeout_hit = (state_q == StBus) && (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_i || state_q != StBus) begin
      cnt_q <= '0;
    end else if (!bus_ack && !bus_err) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  // No timeout: bus cycles wait indefinitely. TIMEOUT is only referenced.
  assign timeout_hit = 1'b0 & (TIMEOUT == 0);
`endif

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    size_d       = size_q;
    dest_d       = dest_q;
    wr_d         = wr_q;
    sp_new_d     = sp_new_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    adr_d        = adr_q;
    sel_d        = sel_q;
    dat_d        = dat_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    wen_d        = 2'b00;
    sp_data_d    = sp_data_q;
    sp_en_d      = 2'b00;
    fault_d      = 1'b0;
    fault_addr_d = fault_addr_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (!is_mem) begin
            if (in_wr) begin
              wen_d   = SZ_WORD;
              waddr_d = in_dest;
              wdata_d = in_data;
            end
          end else if (al_misalign) begin
            fault_d      = 1'b1;
            fault_addr_d = acc_adr;
          end else begin
            state_d  = StBus;
            op_d     = in_op_e;
            size_d   = acc_size;
            dest_d   = in_dest;
            wr_d     = in_wr;
            sp_new_d = (in_op_e == MemPop) ? in_sp + WIDTH'(SP_STEP)
                                           : in_sp - WIDTH'(SP_STEP);
            cyc_d    = 1'b1;
            we_d     = (in_op_e == MemStore) || (in_op_e == MemPush);
            adr_d    = acc_adr;
            sel_d    = al_sel;
            dat_d    = al_st;
          end
        end
      end
      StBus: begin
        // err beats ack; ack beats a timeout landing in the same cycle
        if (bus_err || (timeout_hit && !bus_ack)) begin
          state_d      = StIdle;
          cyc_d        = 1'b0;
          we_d         = 1'b0;
          fault_d      = 1'b1;
          fault_addr_d = adr_q;
        end else if (bus_ack) begin
          state_d = StWb;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          case (op_q)
            MemLoad: begin
              if (wr_q) begin
                wen_d   = size_q;
                waddr_d = dest_q;
                wdata_d = al_ld;
              end
            end
            MemPush: begin
              sp_en_d   = 2'b11;
              sp_data_d = sp_new_q;
            end
            MemPop: begin
              wen_d     = SZ_WORD;
              waddr_d   = dest_q;
              wdata_d   = al_ld;
              sp_en_d   = 2'b11;
              sp_data_d = sp_new_q;
            end
            default: wen_d = 2'b00;
          endcase
        end
      end
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= StIdle;
      op_q         <= MemNone;
      size_q       <= 2'b00;
      dest_q       <= '0;
      wr_q         <= 1'b0;
      sp_new_q     <= '0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      sel_q        <= 4'b0000;
      dat_q        <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      wen_q        <= 2'b00;
      sp_data_q    <= '0;
      sp_en_q      <= 2'b00;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      size_q       <= size_d;
      dest_q       <= dest_d;
      wr_q         <= wr_d;
      sp_new_q     <= sp_new_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      sel_q        <= sel_d;
      dat_q        <= dat_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      wen_q        <= wen_d;
      sp_data_q    <= sp_data_d;
      sp_en_q      <= sp_en_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign in_ready      = (state_q == StIdle);
  assign bus_cyc       = cyc_q;
  assign bus_stb       = cyc_q;
  assign bus_we        = we_q;
  assign bus_adr       = adr_q;
  assign bus_sel       = sel_q;
  assign bus_dat_o     = dat_q;
  assign rf_write_addr = waddr_q;
  assign rf_write_data = wdata_q;
  assign rf_write_en   = wen_q;
  assign rf_sp_data    = sp_data_q;
  assign rf_sp_en      = sp_en_q;
  assign fault         = fault_q;
  assign fault_addr    = fault_addr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomised ops,
// checked against a transaction-level model of the stage's rules.
module tb_mem_stage;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_PUSH  = 3'd3;
  localparam logic [2:0] OP_POP   = 3'd4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        in_valid, in_ready;
  logic [2:0]  in_op;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_data, in_sp;
  logic [3:0]  in_dest;
  logic        in_wr;
  logic        bus_cyc, bus_stb, bus_we;
  logic [31:0] bus_adr, bus_dat_o, bus_dat_i;
  logic [3:0]  bus_sel;
  logic        bus_ack, bus_err;
  logic [3:0]  rf_write_addr;
  logic [31:0] rf_write_data, rf_sp_data, fault_addr;
  logic [1:0]  rf_write_en, rf_sp_en;
  logic        fault;

  mem_stage #(.WIDTH(32), .COUNTP(4), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_size(in_size),
    .in_addr(in_addr), .in_data(in_data), .in_dest(in_dest), .in_wr(in_wr), .in_sp(in_sp),
    .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_adr(bus_adr),
    .bus_sel(bus_sel), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i),
    .bus_ack(bus_ack), .bus_err(bus_err),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data), .rf_write_en(rf_write_en),
    .rf_sp_data(rf_sp_data), .rf_sp_en(rf_sp_en), .fault(fault), .fault_addr(fault_addr)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  logic [31:0] fault_addr_m = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_bytes(input logic [2:0] op, input logic [1:0] size);
    if (op == OP_PUSH || op == OP_POP) return 4;
    if (size == 2'd1) return 1;
    if (size == 2'd2) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] m_adr(input logic [2:0] op, input logic [31:0] addr,
                                        input logic [31:0] sp);
    if (op == OP_PUSH) return sp - 32'd4;
    if (op == OP_POP) return sp;
    return addr;
  endfunction

  function automatic logic [3:0] m_sel(input int nb, input logic [31:0] adr);
    if (nb == 1) return 4'(8 >> (adr % 4));
    if (nb == 2) return ((adr % 4) < 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_repl(input int nb, input logic [31:0] d);
    if (nb == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (nb == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_extract(input int nb, input logic [31:0] adr,
                                            input logic [31:0] d);
    int unsigned shift;
    logic [31:0] mask;
    shift = 8 * (4 - nb - (adr % 4));
    mask  = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    return (d >> shift) & mask;
  endfunction

  // ---------------- drivers ----------------
  task automatic issue(input logic [2:0] op, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] dest, input logic wr,
                       input logic [31:0] sp);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check_eq("ready_wait", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_op = op; in_size = size; in_addr = addr;
    in_data = data; in_dest = dest; in_wr = wr; in_sp = sp;
    @(negedge clk_i);
    in_valid = 1'b0;
  endtask

  task automatic run_none(input logic [3:0] dest, input logic [31:0] data, input logic wr);
    issue(OP_NONE, 2'($urandom), $urandom, data, dest, wr, $urandom);
    check_eq("none_en", {rf_write_en, rf_sp_en}, wr ? 32'hC : 32'h0);
    if (wr) begin
      check_eq("none_addr", rf_write_addr, dest);
      check_eq("none_data", rf_write_data, data);
    end
    check_eq("none_ready", in_ready, 1);
  endtask

  // resp: 0 = ack, 1 = err, 2 = ack and err together
  task automatic run_mem(input logic [2:0] op, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] dest, input logic wr,
                         input logic [31:0] sp, input int waits, input int resp,
                         input logic [31:0] rdata);
    int nb;
    logic [31:0] adr;
    logic we;
    logic [1:0] wen_e, spen_e;
    logic [31:0] wdata_e, spdata_e;
    nb  = m_bytes(op, size);
    adr = m_adr(op, addr, sp);
    we  = (op == OP_STORE) || (op == OP_PUSH);
    issue(op, size, addr, data, dest, wr, sp);
    if ((adr % nb) != 0) begin
      fault_addr_m = adr;
      check_eq("mis_cyc", bus_cyc, 0);
      check_eq("mis_fault", fault, 1);
      check_eq("mis_faddr", fault_addr, adr);
      check_eq("mis_rf", {rf_write_en, rf_sp_en}, 0);
      @(negedge clk_i);
      check_eq("mis_pulse", fault, 0);
      return;
    end
    check_eq("bus_req", {bus_cyc, bus_stb, bus_we, bus_sel}, {1'b1, 1'b1, we, m_sel(nb, adr)});
    check_eq("bus_adr", bus_adr, adr);
    if (we) check_eq("bus_dat", bus_dat_o, m_repl(nb, data));
    check_eq("busy", in_ready, 0);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk_i);
      check_eq("bus_hold", {bus_cyc, bus_stb, bus_sel, in_ready}, {1'b1, 1'b1, m_sel(nb, adr), 1'b0});
      check_eq("bus_hold_adr", bus_adr, adr);
    end
    bus_dat_i = rdata;
    bus_ack = (resp != 1);
    bus_err = (resp != 0);
    @(negedge clk_i);
    bus_ack = 1'b0;
    bus_err = 1'b0;
    bus_dat_i = $urandom;
    if (resp != 0) begin
      fault_addr_m = adr;
      check_eq("err_fault", fault, 1);
      check_eq("err_faddr", fault_addr, adr);
      check_eq("err_state", {bus_cyc, bus_stb, in_ready}, 3'b001);
      check_eq("err_rf", {rf_write_en, rf_sp_en}, 0);
    end else begin
      wen_e = 2'd0; spen_e = 2'd0; wdata_e = 32'h0; spdata_e = 32'h0;
      if (op == OP_LOAD && wr) begin
        wen_e = 2'(nb == 4 ? 3 : nb);
        wdata_e = m_extract(nb, adr, rdata);
      end else if (op == OP_POP) begin
        wen_e = 2'd3; wdata_e = rdata; spen_e = 2'd3; spdata_e = sp + 32'd4;
      end else if (op == OP_PUSH) begin
        spen_e = 2'd3; spdata_e = sp - 32'd4;
      end
      check_eq("wb_state", {bus_cyc, bus_stb, in_ready, fault}, 4'b0000);
      check_eq("wb_en", {rf_write_en, rf_sp_en}, {wen_e, spen_e});
      if (wen_e != 0) begin
        check_eq("wb_addr", rf_write_addr, dest);
        check_eq("wb_data", rf_write_data, wdata_e);
      end
      if (spen_e != 0) check_eq("wb_sp", rf_sp_data, spdata_e);
      @(negedge clk_i);
      check_eq("post_wb", {in_ready, rf_write_en, rf_sp_en}, 5'b10000);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] addr, sp;
    int          r;
    in_valid = 1'b0; in_op = 3'd0; in_size = 2'd0; in_addr = 32'h0; in_data = 32'h0;
    in_dest = 4'd0; in_wr = 1'b0; in_sp = 32'h0;
    bus_dat_i = 32'h0; bus_ack = 1'b0; bus_err = 1'b0;
    repeat (3) @(negedge clk_i);

    check_eq("rst_ready", in_ready, 1);
    check_eq("rst_bus", {bus_cyc, bus_stb, bus_we, bus_sel}, 0);
    check_eq("rst_rf", {rf_write_en, rf_sp_en, fault}, 0);
    check_eq("rst_faddr", fault_addr, 0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Directed cases
    run_none(4'd3, 32'h1234_5678, 1'b1);
    in_valid = 1'b1; in_op = OP_NONE; in_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_dest = 4'(i);
      in_data = 32'hA0 + i;
      @(negedge clk_i);
      check_eq("b2b_addr", rf_write_addr, i);
      check_eq("b2b_data", rf_write_data, 32'hA0 + i);
      check_eq("b2b_en", {rf_write_en, in_ready}, 3'b111);
    end
    in_valid = 1'b0;
    @(negedge clk_i);

    run_mem(OP_LOAD, 2'd1, 32'h1001, 32'h0, 4'd5, 1'b1, 32'h0, 3, 0, 32'hAABB_CCDD);
    run_mem(OP_PUSH, 2'd0, 32'h0, 32'hCAFE_BABE, 4'd0, 1'b0, 32'h1000, 1, 0, 32'h0);
    run_mem(OP_POP, 2'd0, 32'h0, 32'h0, 4'd15, 1'b1, 32'h0FFC, 2, 0, 32'h55);
    run_mem(OP_LOAD, 2'd2, 32'h2003, 32'h0, 4'd1, 1'b1, 32'h0, 0, 0, 32'h0);
    run_mem(OP_STORE, 2'd3, 32'h500, 32'h1122_3344, 4'd0, 1'b0, 32'h0, 0, 2, 32'h0);
    run_mem(OP_PUSH, 2'd3, 32'h0, 32'h7777_0000, 4'd0, 1'b0, 32'h0, 0, 0, 32'h0);
    run_mem(OP_LOAD, 2'd2, 32'h3002, 32'h0, 4'd7, 1'b1, 32'h0, 0, 0, 32'h1234_ABCD);
    run_mem(OP_STORE, 2'd1, 32'h3003, 32'h0000_00E5, 4'd0, 1'b0, 32'h0, 1, 0, 32'h0);

    // Reset in the middle of a bus cycle drops the op
    issue(OP_LOAD, 2'd3, 32'h3000, 32'h0, 4'd2, 1'b1, 32'h0);
    check_eq("rst_mid_pre", bus_cyc, 1);
    rst_i = 1'b0;
    @(negedge clk_i);
    fault_addr_m = 32'h0;
    check_eq("rst_mid_bus", {bus_cyc, bus_stb, bus_we, in_ready}, 4'b0001);
    check_eq("rst_mid_faddr", fault_addr, fault_addr_m);
    rst_i = 1'b1;
    bus_ack = 1'b1;
    bus_dat_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    bus_ack = 1'b0;
    check_eq("ack_idle", {rf_write_en, rf_sp_en, bus_cyc, fault, in_ready}, 7'b0000001);

`ifdef MEM_TIMEOUT_EN
    issue(OP_LOAD, 2'd3, 32'h4000, 32'h0, 4'd4, 1'b1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check_eq("to_wait", {bus_cyc, fault}, 2'b10);
      @(negedge clk_i);
    end
    fault_addr_m = 32'h4000;
    check_eq("to_fault", {bus_cyc, fault, in_ready, rf_write_en}, 5'b01100);
    check_eq("to_faddr", fault_addr, fault_addr_m);
`endif

    // Randomised traffic
    for (int k = 0; k < 150; k++) begin
      op = 3'($urandom_range(0, 4));
      if (op == OP_NONE) begin
        run_none(4'($urandom), $urandom, 1'($urandom));
      end else begin
        addr = $urandom;
        if ($urandom_range(0, 3) != 0) addr = addr & ~32'h3;
        sp = $urandom & ~32'h3;
        if ($urandom_range(0, 7) == 0) sp = sp | 32'h2;
        r = $urandom_range(0, 9);
        run_mem(op, 2'($urandom), addr, $urandom, 4'($urandom), 1'($urandom), sp,
                $urandom_range(0, 3), (r == 0) ? 1 : ((r == 1) ? 2 : 0), $urandom);
      end
      check_eq("faddr_hold", fault_addr, fault_addr_m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory/writeback stage of the bexkat1 pipeline, directly upstream of the register file. Accepts one op per handshake from execute and runs at most one classic bus cycle (load/store/push/pop). Drives the register file's general write port (write_addr/write_data/write_en) and stack-pointer port (sp_data_i/sp_en) for exactly one cycle per retired op.

Parameters:
WIDTH, 32, data/address width
COUNTP, 4, register address bits
TIMEOUT, 255, bus-timeout cycle limit (used only with MEM_TIMEOUT_EN)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-low
in_valid  in  1  execute has an op
in_ready  out  1  stage can accept (state==IDLE)
in_op  in  3  mem_op_t: NONE, LOAD, STORE, PUSH, POP
in_size  in  2  1=byte, 2=half, 0/3=word (register-file byte_en encoding)
in_addr  in  WIDTH  effective address (LOAD/STORE)
in_data  in  WIDTH  store data, or ALU result for NONE
in_dest  in  COUNTP  destination register
in_wr  in  1  NONE/LOAD writes in_dest
in_sp  in  WIDTH  current SP (regfile sp_data_o)
bus_cyc, bus_stb, bus_we  out  1 each  bus strobes
bus_adr  out  WIDTH  byte address
bus_sel  out  4  byte lanes, bit3 = byte 0 (big-endian)
bus_dat_o  out  WIDTH  write data, lane-replicated
bus_dat_i  in  WIDTH  read data
bus_ack, bus_err  in  1 each  bus completion / error
rf_write_addr  out  COUNTP  to register file write_addr
rf_write_data  out  WIDTH  right-justified, zero-extended
rf_write_en  out  2  size code, 0 = no write
rf_sp_data  out  WIDTH  new SP
rf_sp_en  out  2  3 = SP write, 0 = none
fault  out  1  one-cycle pulse: misalign/err/timeout
fault_addr  out  WIDTH  faulting address, held until next fault

Behaviour:
- Reset (rst_i low at clk edge): state IDLE; every output 0 except in_ready=1; fault_addr=0. Reset mid-bus-cycle drops cyc/stb immediately; the op is discarded with no register writes.
- States: IDLE, BUS, WB. Accept = in_valid && in_ready.
- IDLE, accept NONE: next cycle rf_write_en=in_wr?3:0, data=in_data; state stays IDLE (1-cycle latency, back-to-back throughput 1/cycle).
- IDLE, accept memory op: capture fields; state BUS; cyc/stb/we/adr/sel/dat_o registered, asserted next cycle.
- PUSH: adr=in_sp-4, word store of in_data. POP: adr=in_sp, word load. Arithmetic modulo 2^WIDTH (SP=0 push wraps to 0xFFFFFFFC).
- Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no bus cycle; next cycle fault=1, fault_addr=addr, no rf writes, IDLE.
- BUS: hold all bus outputs stable until ack or err. On ack: drop cyc/stb; latch read data; state WB. On err: drop strobes, fault pulse, no rf writes, IDLE.
- WB (one cycle): LOAD: rf_write_en=size code if in_wr, data extracted from lane. STORE: no writes. PUSH: rf_sp_en=3, rf_sp_data=in_sp-4. POP: rf_write_en=3 to in_dest AND rf_sp_en=3 with in_sp+4, same cycle (regfile handles simultaneous SP/general write; pop into SP register legal). Then IDLE.
- Memory-op latency: accept -> WB = 2 + bus wait cycles; in_ready low from accept until WB cycle ends.
- ack and err simultaneous: err wins. ack/err in IDLE/WB ignored.
- Lanes: byte n at addr[1:0]=n -> sel=4'b1000>>n, data bits [31-8n:24-8n]; half at 0 -> 1100, at 2 -> 0011; word 1111. Stores replicate byte/half across all lanes.

Optional Feature:
MEM_TIMEOUT_EN: defined -> counter cleared on BUS entry, increments each BUS cycle without ack/err; reaching TIMEOUT ends the cycle as err (fault pulse, fault_addr=bus_adr). Undefined -> no counter; BUS waits indefinitely; TIMEOUT unused.

Decomposition:
- bexkat1_pkg: mem_op_t enum, mem_state_t enum, size codes SZ_BYTE/SZ_HALF/SZ_WORD, SP step constant 4.
- Sub-module mem_lane_align (combinational): sel generation, misalign detect, store replication, load extract/zero-extend; instantiated once.

Test Plan:
- NONE in_wr=1, dest=3, data=0x12345678 -> next cycle rf_write_addr=3, rf_write_en=3, data 0x12345678; back-to-back NONEs retire every cycle.
- LOAD byte addr 0x1001, bus_dat_i=0xAABBCCDD, ack after 3 waits -> sel=0100, rf_write_data=0x000000BB, en=1, in_ready low until WB.
- PUSH in_sp=0x1000, data=0xCAFEBABE -> adr 0xFFC, we=1, sel=1111; WB rf_sp_en=3, sp_data=0xFFC, rf_write_en=0.
- POP in_sp=0x0FFC, dest=15, bus returns 0x55 -> WB rf_write_en=3 data 0x55 to 15 and rf_sp_data=0x1000 same cycle.
- Half LOAD addr 0x2003 -> no cyc, fault pulse, fault_addr=0x2003; STORE with ack+err same cycle -> fault, no writes.
- rst_i low during BUS -> cyc/stb 0 next edge, no WB; with MEM_TIMEOUT_EN, TIMEOUT=4 and no ack -> fault after 4 BUS cycles.
